// File: rtl/mem_port_arbiter.sv
// Multi-port memory arbiter: grants one requester at a time, issues a single
// memory command held for MEM_LATENCY cycles, then pulses done with load data.
module mem_port_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int RR_MODE     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [3*NUM_PORTS-1:0]      func3,
    input  logic [ADDR_W*NUM_PORTS-1:0] addr,
    input  logic [DATA_W*NUM_PORTS-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        done,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic [2:0]                  mem_func3,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     cur;

    logic [IDX_W-1:0]     start;
    logic [IDX_W-1:0]     base;
    logic [NUM_PORTS-1:0] rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;
    logic [IDX_W-1:0]     win;
    logic                 found;

    logic                 w_we;
    logic [2:0]           w_func3;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic                 mis;

    // Rotate the request vector so the search origin sits at bit 0; fixed
    // priority is simply a rotation by zero.
    always_comb begin
        start = (ptr == IDX_W'(NUM_PORTS - 1)) ? '0 : ptr + 1'b1;
        base  = (RR_MODE != 0) ? start : '0;
        rot   = NUM_PORTS'({req, req} >> base);
        found = 1'b0;
        off   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (IDX_W + 1)'(NUM_PORTS)) begin
            sum = sum - (IDX_W + 1)'(NUM_PORTS);
        end
        win = sum[IDX_W-1:0];
    end

    always_comb begin
        w_we    = 1'b0;
        w_func3 = '0;
        w_addr  = '0;
        w_wdata = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (win == IDX_W'(k)) begin
                w_we    = we[k];
                w_func3 = func3[3*k +: 3];
                w_addr  = addr[ADDR_W*k +: ADDR_W];
                w_wdata = wdata[DATA_W*k +: DATA_W];
            end
        end
        // Only the standard halfword/word codes are alignment-checked.
        mis = ((w_func3 == 3'b001 || w_func3 == 3'b101) && w_addr[0]) ||
              ((w_func3 == 3'b010) && (w_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= IDX_W'(NUM_PORTS - 1);
            cur       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_func3 <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (found) begin
                        gnt       <= NUM_PORTS'(1) << win;
                        cur       <= win;
                        ptr       <= win;
                        mem_func3 <= w_func3;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        if (mis) begin
                            state <= RESP;
                            done  <= NUM_PORTS'(1) << win;
                            err   <= 1'b1;
                        end else begin
                            state  <= BUSY;
                            cnt    <= CNT_W'(MEM_LATENCY - 1);
                            mem_rd <= ~w_we;
                            mem_wr <= w_we;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        // mem_rd doubles as the captured "this is a load" flag.
                        if (mem_rd) begin
                            rdata <= mem_rdata;
                        end
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        done   <= NUM_PORTS'(1) << cur;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-port fixed-priority instance driven from a vector table,
// and a 4-port round-robin MEM_LATENCY=3 instance exercised by short sequences.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: defaults (2 ports, fixed priority, latency 1).
    logic        a_rst;
    logic [1:0]  a_req, a_we, a_gnt, a_done;
    logic [2:0]  a_f0, a_f1, a_mem_func3;
    logic [31:0] a_a0, a_a1, a_w1, a_mem_rdata;
    logic        a_err, a_mem_rd, a_mem_wr;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;

    mem_port_arbiter dut_a (
        .clk(clk), .rst(a_rst), .req(a_req), .we(a_we),
        .func3({a_f1, a_f0}), .addr({a_a1, a_a0}), .wdata({a_w1, 32'h0}),
        .gnt(a_gnt), .done(a_done), .err(a_err), .rdata(a_rdata),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_func3(a_mem_func3),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    // Instance B: 4 ports, round-robin, latency 3.
    logic         b_rst;
    logic [3:0]   b_req, b_we, b_gnt, b_done;
    logic [11:0]  b_func3;
    logic [127:0] b_addr, b_wdata;
    logic         b_err, b_mem_rd, b_mem_wr;
    logic [2:0]   b_mem_func3;
    logic [31:0]  b_rdata, b_mem_addr, b_mem_wdata;
    logic [31:0]  b_mem_rdata = 32'h0BAD_F00D;

    mem_port_arbiter #(.NUM_PORTS(4), .RR_MODE(1), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst(b_rst), .req(b_req), .we(b_we),
        .func3(b_func3), .addr(b_addr), .wdata(b_wdata),
        .gnt(b_gnt), .done(b_done), .err(b_err), .rdata(b_rdata),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_func3(b_mem_func3),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [2:0]  f0;
        logic [31:0] a0;
        logic [2:0]  f1;
        logic [31:0] a1;
        logic [31:0] w1;
        logic [31:0] mrd;
        logic [1:0]  e_gnt;
        logic [1:0]  e_done;
        logic        e_err;
        logic [31:0] e_rdata;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vector(input vec_t v);
        a_rst = v.rst; a_req = v.req; a_we = v.we;
        a_f0 = v.f0; a_a0 = v.a0; a_f1 = v.f1; a_a1 = v.a1;
        a_w1 = v.w1; a_mem_rdata = v.mrd;
    endtask

    task automatic check_vector(input int i, input vec_t v);
        check($sformatf("v%0d.gnt", i),   32'(a_gnt),   32'(v.e_gnt));
        check($sformatf("v%0d.done", i),  32'(a_done),  32'(v.e_done));
        check($sformatf("v%0d.err", i),   32'(a_err),   32'(v.e_err));
        check($sformatf("v%0d.rdata", i), a_rdata,      v.e_rdata);
        check($sformatf("v%0d.mem_rd", i), 32'(a_mem_rd), 32'(v.e_rd));
        check($sformatf("v%0d.mem_wr", i), 32'(a_mem_wr), 32'(v.e_wr));
        check($sformatf("v%0d.mem_addr", i), a_mem_addr, v.e_addr);
        check($sformatf("v%0d.mem_wdata", i), a_mem_wdata, v.e_wdata);
    endtask

    initial begin
        logic [3:0] got[5];
        logic [3:0] exp_order[5];
        int n;
        int wr_cnt;
        int rd_cnt;
        int done_cyc;
        int stray;
        logic stable;

        // rst, req, we, f0, a0, f1, a1, w1, mrd | gnt, done, err, rdata, rd, wr, addr, wdata
        vecs[0]  = '{1'b0, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 2'b01, 2'b00, 3'b010, 32'h100, 3'b000, 32'h0,   32'h0, 32'hDEADBEEF,
                     2'b01, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0};
        vecs[3]  = '{1'b1, 2'b00, 2'b00, 3'b010, 32'h100, 3'b000, 32'h0,   32'h0, 32'hDEADBEEF,
                     2'b00, 2'b01, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h100, 32'h0};
        vecs[4]  = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h100, 32'h0};
        vecs[5]  = '{1'b1, 2'b11, 2'b00, 3'b010, 32'h200, 3'b010, 32'h300, 32'h0, 32'h0,
                     2'b01, 2'b00, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h200, 32'h0};
        vecs[6]  = '{1'b1, 2'b11, 2'b00, 3'b010, 32'h200, 3'b010, 32'h300, 32'h0, 32'h11111111,
                     2'b00, 2'b01, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h200, 32'h0};
        vecs[7]  = '{1'b1, 2'b11, 2'b00, 3'b010, 32'h200, 3'b010, 32'h300, 32'h0, 32'h0,
                     2'b01, 2'b00, 1'b0, 32'h11111111, 1'b1, 1'b0, 32'h200, 32'h0};
        vecs[8]  = '{1'b1, 2'b10, 2'b00, 3'b010, 32'h200, 3'b010, 32'h300, 32'h0, 32'h22222222,
                     2'b00, 2'b01, 1'b0, 32'h22222222, 1'b0, 1'b0, 32'h200, 32'h0};
        vecs[9]  = '{1'b1, 2'b10, 2'b00, 3'b010, 32'h200, 3'b010, 32'h300, 32'h0, 32'h0,
                     2'b10, 2'b00, 1'b0, 32'h22222222, 1'b1, 1'b0, 32'h300, 32'h0};
        vecs[10] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b010, 32'h300, 32'h0, 32'h33333333,
                     2'b00, 2'b10, 1'b0, 32'h33333333, 1'b0, 1'b0, 32'h300, 32'h0};
        vecs[11] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'h33333333, 1'b0, 1'b0, 32'h300, 32'h0};
        vecs[12] = '{1'b1, 2'b10, 2'b10, 3'b000, 32'h0,   3'b001, 32'h103, 32'hAAAA0000, 32'h0,
                     2'b10, 2'b10, 1'b1, 32'h33333333, 1'b0, 1'b0, 32'h103, 32'hAAAA0000};
        vecs[13] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'h33333333, 1'b0, 1'b0, 32'h103, 32'hAAAA0000};
        vecs[14] = '{1'b1, 2'b10, 2'b10, 3'b000, 32'h0,   3'b001, 32'h102, 32'hCAFEF00D, 32'h0,
                     2'b10, 2'b00, 1'b0, 32'h33333333, 1'b0, 1'b1, 32'h102, 32'hCAFEF00D};
        vecs[15] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h44444444,
                     2'b00, 2'b10, 1'b0, 32'h33333333, 1'b0, 1'b0, 32'h102, 32'hCAFEF00D};
        vecs[16] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'h33333333, 1'b0, 1'b0, 32'h102, 32'hCAFEF00D};
        vecs[17] = '{1'b1, 2'b01, 2'b00, 3'b011, 32'h005, 3'b000, 32'h0,   32'h0, 32'h0,
                     2'b01, 2'b00, 1'b0, 32'h33333333, 1'b1, 1'b0, 32'h005, 32'h0};
        vecs[18] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h55555555,
                     2'b00, 2'b01, 1'b0, 32'h55555555, 1'b0, 1'b0, 32'h005, 32'h0};
        vecs[19] = '{1'b1, 2'b01, 2'b00, 3'b010, 32'h102, 3'b000, 32'h0,   32'h0, 32'h0,
                     2'b01, 2'b01, 1'b1, 32'h55555555, 1'b0, 1'b0, 32'h102, 32'h0};
        vecs[20] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'h55555555, 1'b0, 1'b0, 32'h102, 32'h0};
        vecs[21] = '{1'b1, 2'b01, 2'b00, 3'b110, 32'h003, 3'b000, 32'h0,   32'h0, 32'h0,
                     2'b01, 2'b00, 1'b0, 32'h55555555, 1'b1, 1'b0, 32'h003, 32'h0};
        vecs[22] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h66666666,
                     2'b00, 2'b01, 1'b0, 32'h66666666, 1'b0, 1'b0, 32'h003, 32'h0};
        vecs[23] = '{1'b1, 2'b01, 2'b00, 3'b101, 32'h011, 3'b000, 32'h0,   32'h0, 32'h0,
                     2'b01, 2'b01, 1'b1, 32'h66666666, 1'b0, 1'b0, 32'h011, 32'h0};
        vecs[24] = '{1'b1, 2'b00, 2'b00, 3'b000, 32'h0,   3'b000, 32'h0,   32'h0, 32'h0,
                     2'b00, 2'b00, 1'b0, 32'h66666666, 1'b0, 1'b0, 32'h011, 32'h0};

        apply_vector(vecs[0]);
        b_rst = 1'b0; b_req = '0; b_we = '0; b_func3 = '0; b_addr = '0; b_wdata = '0;
        for (int p = 0; p < 4; p++) begin
            b_func3[3*p +: 3] = 3'b010;
            b_addr[32*p +: 32] = 32'h1000 + 32'(16 * p);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply_vector(vecs[i]);
            @(posedge clk);
            #1;
            check_vector(i, vecs[i]);
        end

        // Round-robin instance: reset state, then all four ports held.
        @(posedge clk);
        #1;
        check("rr.reset_gnt", 32'(b_gnt), 32'h0);
        check("rr.reset_rdata", b_rdata, 32'h0);
        @(negedge clk);
        b_rst = 1'b1;
        b_req = 4'b1111;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(posedge clk);
            #1;
            if (b_gnt != 4'b0000) begin
                got[n] = b_gnt;
                n++;
            end
        end
        check("rr.grant_count", 32'(n), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < n) check($sformatf("rr.order%0d", k), 32'(got[k]), 32'(exp_order[k]));
        end
        b_req = 4'b0000;
        repeat (6) @(posedge clk);
        #1;
        check("rr.load_rdata", b_rdata, 32'h0BADF00D);

        // Latency-3 store: strobe width, stability and done timing.
        @(negedge clk);
        b_req = 4'b0100;
        b_we = 4'b0100;
        b_addr[64 +: 32] = 32'h40;
        b_wdata[64 +: 32] = 32'h12345678;
        @(posedge clk);
        #1;
        check("st.gnt", 32'(b_gnt), 32'h4);
        b_req = 4'b0000;
        wr_cnt = 0; rd_cnt = 0; done_cyc = 0; stable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            if (b_mem_wr) begin
                wr_cnt++;
                if (b_mem_addr !== 32'h40 || b_mem_wdata !== 32'h12345678) stable = 1'b0;
            end
            if (b_mem_rd) rd_cnt++;
            if (b_done[2] && done_cyc == 0) done_cyc = c;
            @(posedge clk);
            #1;
        end
        check("st.wr_cycles", 32'(wr_cnt), 32'd3);
        check("st.rd_cycles", 32'(rd_cnt), 32'd0);
        check("st.stable", 32'(stable), 32'd1);
        check("st.done_cycle", 32'(done_cyc), 32'd4);
        b_we = 4'b0000;

        // Reset during the second busy cycle of a load.
        @(negedge clk);
        b_req = 4'b0010;
        b_addr[32 +: 32] = 32'h80;
        @(posedge clk);
        #1;
        check("ab.gnt", 32'(b_gnt), 32'h2);
        check("ab.mem_rd", 32'(b_mem_rd), 32'h1);
        b_req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        @(posedge clk);
        #1;
        check("ab.gnt", 32'(b_gnt), 32'h0);
        check("ab.done", 32'(b_done), 32'h0);
        check("ab.err", 32'(b_err), 32'h0);
        check("ab.rdata", b_rdata, 32'h0);
        check("ab.strobes", 32'({b_mem_rd, b_mem_wr}), 32'h0);
        check("ab.mem_addr", b_mem_addr, 32'h0);
        check("ab.mem_wdata", b_mem_wdata, 32'h0);
        check("ab.mem_func3", 32'(b_mem_func3), 32'h0);
        b_rst = 1'b1;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (b_done != 4'b0000) stray++;
        end
        check("ab.no_done", 32'(stray), 32'd0);

        // Pointer is back at NUM_PORTS-1, so port 0 beats port 3.
        @(negedge clk);
        b_req = 4'b1001;
        @(posedge clk);
        #1;
        check("ab.regrant", 32'(b_gnt), 32'h1);
        b_req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("ab.redone", 32'(b_done), 32'h1);
        check("ab.rerdata", b_rdata, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
